// File: rtl/transpose_pingpong_buf.sv
// Double-buffered DIMxDIM corner-turn memory: rows stream into one bank while
// the other bank drains as columns, so a block is transposed without bubbles.
module transpose_pingpong_buf #(
  parameter int WIDTH     = 16,
  parameter int DIM       = 8,
  parameter int SEL_WIDTH = $clog2(DIM)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic signed [DIM-1:0][WIDTH-1:0]   in_row,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [DIM-1:0][WIDTH-1:0]   out_col,
  output logic                               out_last
);

  localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(DIM - 1);
  localparam logic [SEL_WIDTH-1:0] ONE  = SEL_WIDTH'(1);

  typedef logic [DIM-1:0][WIDTH-1:0] row_t;

  row_t                 bank_q [2][DIM];
  row_t                 bank_d [2][DIM];
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [SEL_WIDTH-1:0] wr_row_q, wr_row_d;
  logic [SEL_WIDTH-1:0] rd_col_q, rd_col_d;
  logic [1:0]           full_q, full_d;

  logic wr_accept;
  logic rd_xfer;

  // Generic DIM:1 word mux; a select beyond DIM-1 (non power-of-2 DIM) yields 0.
  function automatic logic [WIDTH-1:0] word_mux(input row_t words,
                                                input logic [SEL_WIDTH-1:0] sel);
    logic [WIDTH-1:0] word;
    word = '0;
    for (int i = 0; i < DIM; i++) begin
      if (sel == SEL_WIDTH'(i)) word = words[i];
    end
    return word;
  endfunction

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_last  = out_valid && (rd_col_q == LAST);
  assign wr_accept = in_valid && in_ready;
  assign rd_xfer   = out_valid && out_ready;

  always_comb begin
    out_col = '0;
    for (int r = 0; r < DIM; r++) begin
      out_col[r] = word_mux(bank_q[rd_bank_q][r], rd_col_q);
    end
  end

  // The bank being filled is never the bank being drained, so a fill-complete
  // and a drain-complete in the same cycle touch different full flags.
  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block leaves a
    // signal unassigned, which would otherwise infer a latch.
    bank_d    = bank_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_row_d  = wr_row_q;
    rd_col_d  = rd_col_q;
    full_d    = full_q;

    if (wr_accept) begin
      bank_d[wr_bank_q][wr_row_q] = in_row;
      if (wr_row_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_row_d          = '0;
      end else begin
        wr_row_d = wr_row_q + ONE;
      end
    end

    if (rd_xfer) begin
      if (rd_col_q == LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_col_d          = '0;
      end else begin
        rd_col_d = rd_col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: storage is cleared on reset so out_col reads a defined 0 after
      // reset instead of whatever the registers powered up with.
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < DIM; r++) begin
          bank_q[b][r] <= '0;
        end
      end
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_row_q  <= '0;
      rd_col_q  <= '0;
      full_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      bank_q    <= bank_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_row_q  <= wr_row_d;
      rd_col_q  <= rd_col_d;
      full_q    <= full_d;
    end
  end

endmodule
